// File: rtl/sync_fifo_wr_arbiter.sv
// Write-side arbiter for sync_fifo_2_input: shares the two FIFO write lanes between
// requesters A and B, using a credit count so that the FIFO can never overflow.
module sync_fifo_wr_arbiter #(
   parameter int DATAWIDTH = 8,
   parameter int DEPTH     = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_a,
   input  logic [DATAWIDTH-1:0]   data_a,
   output logic                   gnt_a,
   input  logic                   req_b,
   input  logic [DATAWIDTH-1:0]   data_b,
   output logic                   gnt_b,
   input  logic                   fifo_pop,
   output logic                   fifo_wr_en,
   output logic                   fifo_wr_en_2,
   output logic [DATAWIDTH-1:0]   fifo_wr_data,
   output logic [DATAWIDTH-1:0]   fifo_wr_data_2,
   output logic [$clog2(DEPTH):0] occupancy,
   output logic                   underflow_err
);

   localparam int OCC_W = $clog2(DEPTH) + 1;

   typedef enum logic {PRIO_A, PRIO_B} prio_e;

   prio_e                prio_q, prio_d;
   logic [OCC_W-1:0]     occ_q, occ_d;
   logic [OCC_W-1:0]     free;
   logic                 pop_eff;
   logic                 wr_en_q, wr_en_d;
   logic                 wr_en_2_q, wr_en_2_d;
   logic [DATAWIDTH-1:0] wr_data_q, wr_data_d;
   logic [DATAWIDTH-1:0] wr_data_2_q, wr_data_2_d;
   logic                 underflow_q, underflow_d;

   // Credits come from the registered count only; a pop this cycle frees a slot next cycle.
   always_comb begin
      free   = OCC_W'(DEPTH) - occ_q;
      gnt_a  = 1'b0;
      gnt_b  = 1'b0;
      prio_d = prio_q;
      if (rst) begin
         if (free >= OCC_W'(2)) begin
            gnt_a = req_a;
            gnt_b = req_b;
         end else if (free == OCC_W'(1)) begin
            if (req_a && req_b) begin
               gnt_a  = (prio_q == PRIO_A);
               gnt_b  = (prio_q == PRIO_B);
               prio_d = (prio_q == PRIO_A) ? PRIO_B : PRIO_A;
            end else begin
               gnt_a = req_a;
               gnt_b = req_b;
            end
         end
      end
   end

   // A single winner always uses lane 1; lane 2 only carries B when both are granted.
   always_comb begin
      wr_en_d     = gnt_a | gnt_b;
      wr_en_2_d   = gnt_a & gnt_b;
      wr_data_d   = wr_data_q;
      wr_data_2_d = wr_data_2_q;
      if (gnt_a) begin
         wr_data_d = data_a;
      end else if (gnt_b) begin
         wr_data_d = data_b;
      end
      if (gnt_a && gnt_b) begin
         wr_data_2_d = data_b;
      end
      pop_eff     = fifo_pop && (occ_q != '0);
      occ_d       = occ_q + OCC_W'(gnt_a) + OCC_W'(gnt_b) - OCC_W'(pop_eff);
      underflow_d = underflow_q | (fifo_pop && (occ_q == '0));
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         prio_q      <= PRIO_A;
         occ_q       <= '0;
         wr_en_q     <= 1'b0;
         wr_en_2_q   <= 1'b0;
         wr_data_q   <= '0;
         wr_data_2_q <= '0;
         underflow_q <= 1'b0;
      end else begin
         prio_q      <= prio_d;
         occ_q       <= occ_d;
         wr_en_q     <= wr_en_d;
         wr_en_2_q   <= wr_en_2_d;
         wr_data_q   <= wr_data_d;
         wr_data_2_q <= wr_data_2_d;
         underflow_q <= underflow_d;
      end
   end

   assign fifo_wr_en     = wr_en_q;
   assign fifo_wr_en_2   = wr_en_2_q;
   assign fifo_wr_data   = wr_data_q;
   assign fifo_wr_data_2 = wr_data_2_q;
   assign occupancy      = occ_q;
   assign underflow_err  = underflow_q;

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Bench for sync_fifo_wr_arbiter: directed scenarios plus random traffic, checked against
// a credit/priority reference model kept as plain integers.
module tb_sync_fifo_wr_arbiter;

   localparam int DW    = 8;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_a, req_b, fifo_pop;
   logic [DW-1:0] data_a, data_b;
   logic          gnt_a, gnt_b;
   logic          fifo_wr_en, fifo_wr_en_2;
   logic [DW-1:0] fifo_wr_data, fifo_wr_data_2;
   logic [$clog2(DEPTH):0] occupancy;
   logic          underflow_err;

   int errors = 0;
   int checks = 0;

   // reference model state
   int            occ_m;
   bit            prio_m;      // 0 = A holds priority, 1 = B
   bit            uf_m;
   bit            we_m, we2_m;
   logic [DW-1:0] d_m, d2_m;
   bit            last_ga, last_gb;

   always #5 clk = ~clk;

   sync_fifo_wr_arbiter #(.DATAWIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .data_a(data_a), .gnt_a(gnt_a),
      .req_b(req_b), .data_b(data_b), .gnt_b(gnt_b),
      .fifo_pop(fifo_pop),
      .fifo_wr_en(fifo_wr_en), .fifo_wr_en_2(fifo_wr_en_2),
      .fifo_wr_data(fifo_wr_data), .fifo_wr_data_2(fifo_wr_data_2),
      .occupancy(occupancy), .underflow_err(underflow_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      occ_m = 0; prio_m = 0; uf_m = 0;
      we_m = 0; we2_m = 0; d_m = '0; d2_m = '0;
   endtask

   // One clock: drive inputs, check comb grants, clock, check registered state.
   task automatic step(input bit r, input bit ra, input bit rb, input bit p);
      logic [DW-1:0] da, db;
      bit ga, gb;
      int free;
      da = DW'($urandom);
      db = DW'($urandom);
      rst = r; req_a = ra; req_b = rb; fifo_pop = p;
      data_a = da; data_b = db;
      free = DEPTH - occ_m;
      ga = 0; gb = 0;
      if (r) begin
         if (free >= 2) begin
            ga = ra; gb = rb;
         end else if (free == 1) begin
            if (ra && rb) begin
               ga = (prio_m == 0);
               gb = !ga;
            end else begin
               ga = ra; gb = rb;
            end
         end
      end
      last_ga = ga; last_gb = gb;
      #1;
      chk("gnt_a", gnt_a, ga);
      chk("gnt_b", gnt_b, gb);
      @(posedge clk); #1;
      if (!r) begin
         model_reset();
      end else begin
         if (free == 1 && ra && rb) prio_m = !prio_m;
         if (ga && gb) begin
            we_m = 1; we2_m = 1; d_m = da; d2_m = db;
         end else if (ga || gb) begin
            we_m = 1; we2_m = 0; d_m = ga ? da : db;
         end else begin
            we_m = 0; we2_m = 0;
         end
         if (p && occ_m == 0) uf_m = 1;
         occ_m = occ_m + int'(ga) + int'(gb) - ((p && occ_m > 0) ? 1 : 0);
      end
      chk("wr_en", fifo_wr_en, we_m);
      chk("wr_en_2", fifo_wr_en_2, we2_m);
      chk("wr_data", fifo_wr_data, d_m);
      chk("wr_data_2", fifo_wr_data_2, d2_m);
      chk("occupancy", occupancy, occ_m);
      chk("underflow", underflow_err, uf_m);
      chk("occ_bound", (occupancy <= DEPTH), 1);
   endtask

   initial begin
      rst = 0; req_a = 0; req_b = 0; fifo_pop = 0; data_a = '0; data_b = '0;
      model_reset();
      @(posedge clk); #1;
      step(0, 0, 0, 0);
      chk("reset_occ", occupancy, 0);

      // fill with both requesting: four dual grants, then none
      for (int i = 0; i < 4; i++) begin
         step(1, 1, 1, 0);
         chk("fill_dual_a", last_ga, 1);
         chk("fill_dual_b", last_gb, 1);
         chk("fill_occ", occupancy, 2 * (i + 1));
      end
      step(1, 1, 1, 0);
      chk("full_no_gnt", {gnt_a, gnt_b}, 2'b00);
      chk("full_occ", occupancy, DEPTH);

      // pop alongside requests at full: no grant this cycle
      step(1, 1, 1, 1);
      chk("pop_at_full_occ", occupancy, 7);
      // one slot, prio A -> A wins, prio moves to B
      step(1, 1, 1, 0);
      chk("one_slot_a", fifo_wr_data, d_m);
      chk("one_slot_occ", occupancy, 8);
      step(1, 0, 0, 1);
      step(1, 1, 1, 0);
      chk("one_slot_b_wins", {last_ga, last_gb}, 2'b01);

      // only B requests with one slot, prio A: B granted, prio stays A
      step(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 1, 1, 0);
      step(1, 1, 0, 0);
      chk("occ7", occupancy, 7);
      step(1, 0, 1, 0);
      chk("b_alone_wr_en_2", fifo_wr_en_2, 0);
      step(1, 0, 0, 1);
      step(1, 1, 1, 0);
      chk("prio_still_a", {last_ga, last_gb}, 2'b10);

      // underflow is sticky until reset
      step(0, 0, 0, 0);
      step(1, 0, 0, 1);
      chk("underflow_set", underflow_err, 1);
      chk("underflow_occ0", occupancy, 0);
      step(1, 1, 0, 0);
      step(1, 0, 0, 1);
      step(1, 0, 0, 1);
      chk("underflow_sticky", underflow_err, 1);
      step(0, 0, 0, 0);
      chk("underflow_clr", underflow_err, 0);

      // reset while a dual write is registered
      step(1, 1, 1, 0);
      chk("dual_pending", {fifo_wr_en, fifo_wr_en_2}, 2'b11);
      step(0, 1, 1, 0);
      chk("rst_drop_wr", {fifo_wr_en, fifo_wr_en_2}, 2'b00);
      chk("rst_drop_occ", occupancy, 0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) != 0), bit'($urandom), bit'($urandom),
              ($urandom_range(0, 2) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
